// File: rtl/frame_pkg.sv
// Shared frame-buffer geometry and arbiter index constants for the
// pixel-fetch / encoded-byte-writeback BRAM path.
package frame_pkg;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 8;
  localparam int FRAME_PIX  = 307200;
  localparam int FRAME_LAST = FRAME_PIX - 1;

  // Bit positions of the two requesters in the arbiter request/grant vectors
  localparam int RD_IDX = 0;
  localparam int WR_IDX = 1;

  typedef enum logic {
    SERVED_RD = 1'b0,
    SERVED_WR = 1'b1
  } served_e;

endpackage

// File: rtl/frame_bram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the requests and the
// last-served pointer; the pointer moves only when something is granted.
module rr_arb2
  import frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  served_e last_served;

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_served == SERVED_WR) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_served <= SERVED_RD;
    end else if (|gnt) begin
      last_served <= gnt[WR_IDX] ? SERVED_WR : SERVED_RD;
    end
  end

endmodule

// File: rtl/frame_bram_arbiter.sv
// Shares one single-port frame BRAM between the pixel-fetch reader and the
// encoded-byte writer, with range checking and a written-pixel counter.
module frame_bram_arbiter #(
  parameter int ADDR_W    = frame_pkg::ADDR_W,
  parameter int DATA_W    = frame_pkg::DATA_W,
  parameter int FRAME_PIX = frame_pkg::FRAME_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              addr_err,
  output logic [ADDR_W-1:0] wr_count,
  output logic              frame_written
);

  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W+1)'(FRAME_PIX);
  localparam logic [ADDR_W-1:0] COUNT_MAX = ADDR_W'(FRAME_PIX);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       rd_in_range;
  logic       wr_in_range;
  logic       rd_pend;
  logic       rd_pend_oor;

  assign req = {wr_req, rd_req};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign rd_gnt = gnt[frame_pkg::RD_IDX];
  assign wr_gnt = gnt[frame_pkg::WR_IDX];

  assign rd_in_range = {1'b0, rd_addr} < PIX_LIMIT;
  assign wr_in_range = {1'b0, wr_addr} < PIX_LIMIT;

  // Out-of-range requests are still granted but never reach the BRAM
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (wr_gnt) begin
      bram_en   = wr_in_range;
      bram_we   = 1'b1;
      bram_addr = wr_addr;
      bram_din  = wr_data;
    end else if (rd_gnt) begin
      bram_en   = rd_in_range;
      bram_addr = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend     <= 1'b0;
      rd_pend_oor <= 1'b0;
      addr_err    <= 1'b0;
      wr_count    <= '0;
    end else begin
      rd_pend     <= rd_gnt;
      rd_pend_oor <= rd_gnt & ~rd_in_range;
      if ((rd_gnt & ~rd_in_range) | (wr_gnt & ~wr_in_range)) begin
        addr_err <= 1'b1;
      end
      if (wr_gnt && wr_in_range && (wr_count != COUNT_MAX)) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  // A reset arriving in the data-return cycle kills the read in flight
  assign rd_valid      = rd_pend & ~rst;
  assign rd_data       = (rd_valid && !rd_pend_oor) ? bram_dout : '0;
  assign frame_written = (wr_count == COUNT_MAX);

endmodule

// File: tb/tb_frame_bram_arbiter.sv
// Bench for frame_bram_arbiter with a shrunken frame so the fill-to-full
// scenario stays short; a behavioural model is compared on every cycle.
module tb_frame_bram_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int FP = 64;
  localparam int BIG_ADDR = 307200;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          addr_err;
  logic [AW-1:0] wr_count;
  logic          frame_written;

  always #5 clk = ~clk;

  frame_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FRAME_PIX(FP)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_gnt        (wr_gnt),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_dout     (bram_dout),
    .addr_err      (addr_err),
    .wr_count      (wr_count),
    .frame_written (frame_written)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    if (i == 5) return 8'hA3;
    if (i == 7) return 8'h11;
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Single-port BRAM, read-first, one cycle of read latency
  logic [7:0] bram_mem [0:255];
  initial begin
    bram_dout = '0;
    for (int i = 0; i < 256; i++) bram_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (bram_en) begin
        bram_dout <= bram_mem[bram_addr[7:0]];
        if (bram_we) bram_mem[bram_addr[7:0]] <= bram_din;
      end
    end
  end

  // Reference model: what each requester should see, from the rules alone
  logic [7:0] ref_mem [0:255];
  bit         m_last_wr;
  bit         m_pend;
  logic [7:0] m_pend_data;
  bit         m_err;
  int         m_cnt;
  bit         model_live = 1'b0;

  function automatic void exp_grants(output bit gr, output bit gw);
    gw = !rst && wr_req && (!rd_req || !m_last_wr);
    gr = !rst && rd_req && !gw;
  endfunction

  initial begin
    bit gr, gw;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    m_last_wr = 1'b0; m_pend = 1'b0; m_pend_data = '0; m_err = 1'b0; m_cnt = 0;
    forever begin
      @(posedge clk);
      exp_grants(gr, gw);
      if (rst) begin
        m_last_wr = 1'b0; m_pend = 1'b0; m_pend_data = '0; m_err = 1'b0; m_cnt = 0;
      end else begin
        m_pend      = gr;
        m_pend_data = (gr && rd_addr < FP) ? ref_mem[rd_addr[7:0]] : 8'h00;
        if (gr && rd_addr >= FP) m_err = 1'b1;
        if (gw) begin
          if (wr_addr < FP) begin
            ref_mem[wr_addr[7:0]] = wr_data;
            if (m_cnt < FP) m_cnt++;
          end else begin
            m_err = 1'b1;
          end
        end
        if (gr || gw) m_last_wr = gw;
      end
      model_live = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit gr, gw, en, v;
    if (model_live) begin
      exp_grants(gr, gw);
      en = (gr && rd_addr < FP) || (gw && wr_addr < FP);
      v  = m_pend && !rst;
      check("rd_gnt", 32'(rd_gnt), 32'(gr));
      check("wr_gnt", 32'(wr_gnt), 32'(gw));
      check("one_gnt", 32'(rd_gnt & wr_gnt), 32'd0);
      check("bram_en", 32'(bram_en), 32'(en));
      check("bram_we", 32'(bram_we), 32'(gw));
      if (en) check("bram_addr", 32'(bram_addr), gw ? 32'(wr_addr) : 32'(rd_addr));
      if (en && gw) check("bram_din", 32'(bram_din), 32'(wr_data));
      check("rd_valid", 32'(rd_valid), 32'(v));
      check("rd_data", 32'(rd_data), v ? 32'(m_pend_data) : 32'd0);
      check("addr_err", 32'(addr_err), 32'(m_err));
      check("wr_count", 32'(wr_count), 32'(m_cnt));
      check("frame_written", 32'(frame_written), 32'(m_cnt == FP));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned p = $urandom_range(0, 99);
    if (p < 90) return AW'($urandom_range(0, FP - 1));
    if (p < 95) return AW'(FP + $urandom_range(0, 3));
    return AW'(BIG_ADDR);
  endfunction

  initial begin
    bit rg, wg;
    bit exp_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    do_reset();

    @(negedge clk);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_frame_written", 32'(frame_written), 32'd0);

    // Contention right after reset: write wins first, then alternate
    tick();
    rd_req = 1'b1; rd_addr = AW'(30);
    wr_req = 1'b1; wr_addr = AW'(20); wr_data = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr_wr_gnt_%0d", k), 32'(wr_gnt), 32'(exp_w[k]));
      check($sformatf("rr_rd_gnt_%0d", k), 32'(rd_gnt), 32'(!exp_w[k]));
      tick();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    tick();

    // Plain read of a preloaded pixel
    rd_req = 1'b1; rd_addr = AW'(5);
    @(negedge clk);
    check("rd5_gnt", 32'(rd_gnt), 32'd1);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    check("rd5_valid", 32'(rd_valid), 32'd1);
    check("rd5_data", 32'(rd_data), 32'hA3);
    tick();

    // Read then write to the same address: read returns the old byte
    rd_req = 1'b1; rd_addr = AW'(7);
    tick();
    rd_req = 1'b0;
    wr_req = 1'b1; wr_addr = AW'(7); wr_data = 8'h22;
    @(negedge clk);
    check("rw7_wr_gnt", 32'(wr_gnt), 32'd1);
    check("rw7_old_data", 32'(rd_data), 32'h11);
    tick();
    wr_req = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = AW'(7);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    check("rw7_new_data", 32'(rd_data), 32'h22);
    tick();

    // Out-of-range write: granted, BRAM untouched, sticky error, no count
    wr_req = 1'b1; wr_addr = AW'(BIG_ADDR); wr_data = 8'h77;
    @(negedge clk);
    check("oor_wr_gnt", 32'(wr_gnt), 32'd1);
    check("oor_bram_en", 32'(bram_en), 32'd0);
    tick();
    wr_req = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("oor_err_sticky", 32'(addr_err), 32'd1);
    check("oor_count_held", 32'(wr_count), 32'd3);

    // Out-of-range read at the first address past the frame returns zero
    rd_req = 1'b1; rd_addr = AW'(FP);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    check("oor_rd_valid", 32'(rd_valid), 32'd1);
    check("oor_rd_data", 32'(rd_data), 32'd0);

    // Reset in the return cycle of a read drops it and clears everything
    tick();
    rd_req = 1'b1; rd_addr = AW'(FP - 1);
    tick();
    rd_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_drop_valid", 32'(rd_valid), 32'd0);
    check("rst_drop_gnt", 32'(rd_gnt), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_valid", 32'(rd_valid), 32'd0);
    check("rst_after_err", 32'(addr_err), 32'd0);
    check("rst_after_count", 32'(wr_count), 32'd0);

    // Fill the whole frame, then one overwrite past saturation
    wr_req = 1'b1;
    for (int i = 0; i < FP; i++) begin
      wr_addr = AW'(i);
      wr_data = 8'($urandom);
      tick();
    end
    @(negedge clk);
    check("fill_frame_written", 32'(frame_written), 32'd1);
    check("fill_count", 32'(wr_count), 32'(FP));
    wr_addr = AW'(3); wr_data = 8'hC6;
    @(negedge clk);
    check("over_wr_gnt", 32'(wr_gnt), 32'd1);
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    check("over_count_held", 32'(wr_count), 32'(FP));
    check("over_frame_written", 32'(frame_written), 32'd1);

    // Randomised traffic honouring the hold-until-granted handshake
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rg = rd_gnt;
      wg = wr_gnt;
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (!rd_req || rg) begin
        rd_req  = ($urandom_range(0, 99) < 60);
        rd_addr = rand_addr();
      end
      if (!wr_req || wg) begin
        wr_req  = ($urandom_range(0, 99) < 55);
        wr_addr = rand_addr();
        wr_data = 8'($urandom);
      end
    end
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
